// File: rtl/diff_rx_pkg.sv
// Shared definitions for the differential receive word aligner:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package diff_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Never returns less than 1 so that counters always have at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/diff_rx_sync_detect.sv
// Serial shift window, fill tracking and sync-word comparator.
// window/match/filled describe the register contents after the current bit is shifted in.
module diff_rx_sync_detect
    import diff_rx_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hBC
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic             d_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] window_o,
    output logic             match_o,
    output logic             filled_o
);
    localparam int             FCW       = clog2(WIDTH + 1);
    localparam logic [FCW-1:0] FILL_FULL = FCW'(WIDTH);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [FCW-1:0]   fill_q;
    logic [FCW-1:0]   fill_d;
    logic [FCW-1:0]   fill_inc;

    always_comb begin
        sr_d     = en_i ? {sr_q[WIDTH-2:0], d_i} : sr_q;
        fill_inc = (en_i && (fill_q != FILL_FULL)) ? fill_q + 1'b1 : fill_q;
        // Clearing discards the bit shifted this cycle from the fill count.
        fill_d   = clr_i ? '0 : fill_inc;
    end

    assign window_o = sr_d;
    assign match_o  = (sr_d == SYNC_WORD);
    assign filled_o = (fill_inc == FILL_FULL);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/diff_rx_word_aligner.sv
// Sync-word hunting, frame-boundary locking and parallel word output for a
// sampled serial bit stream from a differential receive buffer.
module diff_rx_word_aligner
    import diff_rx_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD    = 8'hBC,
    parameter int               FRAME_LEN    = 16,
    parameter int               LOCK_COUNT   = 2,
    parameter int               UNLOCK_COUNT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             D,
    output logic [WIDTH-1:0] DATA,
    output logic             DATA_VALID,
    output logic             SOF,
    output logic             LOCKED,
    output logic             SYNC_ERR
);
    localparam int BCW = clog2(WIDTH);
    localparam int WIW = clog2(FRAME_LEN);
    localparam int GCW = clog2(LOCK_COUNT + 1);
    localparam int MCW = clog2(UNLOCK_COUNT + 1);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [WIW-1:0] IDX_LAST = WIW'(FRAME_LEN - 1);
    localparam logic [GCW-1:0] GOOD_TGT = GCW'(LOCK_COUNT);
    localparam logic [MCW-1:0] MISS_TGT = MCW'(UNLOCK_COUNT);

    state_t           state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIW-1:0]   word_idx_q, word_idx_d;
    logic [GCW-1:0]   good_q, good_d, good_inc;
    logic [MCW-1:0]   miss_q, miss_d, miss_inc;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dv_q, dv_d;
    logic             sof_q, sof_d;
    logic             serr_q, serr_d;

    logic [WIDTH-1:0] window;
    logic             match;
    logic             filled;
    logic             clr_fill;
    logic             word_done;
    logic             sync_slot;

    diff_rx_sync_detect #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk_i    (CLK),
        .srst_i   (RST),
        .en_i     (EN),
        .d_i      (D),
        .clr_i    (clr_fill),
        .window_o (window),
        .match_o  (match),
        .filled_o (filled)
    );

    // word_idx_q is the frame index of the word currently being received.
    assign word_done = EN && (state_q != ST_HUNT) && (bit_cnt_q == BIT_LAST);
    assign sync_slot = word_done && (word_idx_q == '0);
    assign good_inc  = good_q + 1'b1;
    assign miss_inc  = miss_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        good_d     = good_q;
        miss_d     = miss_q;
        data_d     = data_q;
        dv_d       = 1'b0;
        sof_d      = 1'b0;
        serr_d     = 1'b0;
        clr_fill   = 1'b0;

        if (EN && (state_q != ST_HUNT)) begin
            bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
        end
        if (word_done) begin
            word_idx_d = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + 1'b1;
        end

        case (state_q)
            ST_HUNT: begin
                if (EN && filled && match) begin
                    bit_cnt_d  = '0;
                    word_idx_d = WIW'(1);
                    good_d     = GCW'(1);
                    miss_d     = '0;
                    state_d    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (sync_slot) begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_TGT) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d   = ST_HUNT;
                        clr_fill  = 1'b1;
                        good_d    = '0;
                        miss_d    = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (word_done) begin
                    if (word_idx_q != '0) begin
                        data_d = window;
                        dv_d   = 1'b1;
                        sof_d  = (word_idx_q == WIW'(1));
                    end else if (match) begin
                        miss_d = '0;
                    end else begin
                        serr_d = 1'b1;
                        miss_d = miss_inc;
                        if (miss_inc == MISS_TGT) begin
                            state_d   = ST_HUNT;
                            clr_fill  = 1'b1;
                            good_d    = '0;
                            miss_d    = '0;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_HUNT;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            sof_q      <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_idx_q <= word_idx_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            sof_q      <= sof_d;
            serr_q     <= serr_d;
        end
    end

    assign DATA       = data_q;
    assign DATA_VALID = dv_q;
    assign SOF        = sof_q;
    assign SYNC_ERR   = serr_q;
    assign LOCKED     = (state_q == ST_LOCKED);

endmodule
